// File: rtl/alu_unit.sv
// 8-bit ALU with combinational result and a registered {Z,C,N,O} flag set.
// Build option: define ALU_UNIT_OVERFLOW_EN to enable the O flag (otherwise O stays 0).
module alu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] FunSel,
  output logic [7:0] OutALU,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    OP_PASS_A = 4'h0,
    OP_PASS_B = 4'h1,
    OP_NOT_A  = 4'h2,
    OP_NOT_B  = 4'h3,
    OP_ADD    = 4'h4,
    OP_SUB    = 4'h5,
    OP_CMP    = 4'h6,
    OP_AND    = 4'h7,
    OP_OR     = 4'h8,
    OP_NAND   = 4'h9,
    OP_XOR    = 4'hA,
    OP_LSL    = 4'hB,
    OP_LSR    = 4'hC,
    OP_ASL    = 4'hD,
    OP_ASR    = 4'hE,
    OP_CSR    = 4'hF
  } op_e;

  op_e        op;
  logic [8:0] add_sum;
  logic [8:0] sub_sum;
  logic       a_gt_b;
  logic [7:0] result;
  logic [7:0] flag_src;

  logic z_d, c_d, n_d, o_d;
  logic z_q, c_q, n_q, o_q;

  assign op = op_e'(FunSel);

  // Subtraction is formed as A + ~B + 1 so bit 8 is the no-borrow carry.
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + 9'd1;
  assign a_gt_b  = (A > B);

  always_comb begin
    result = 8'h00;
    case (op)
      OP_PASS_A: result = A;
      OP_PASS_B: result = B;
      OP_NOT_A:  result = ~A;
      OP_NOT_B:  result = ~B;
      OP_ADD:    result = add_sum[7:0];
      OP_SUB:    result = sub_sum[7:0];
      OP_CMP:    result = a_gt_b ? A : 8'h00;
      OP_AND:    result = A & B;
      OP_OR:     result = A | B;
      OP_NAND:   result = ~(A & B);
      OP_XOR:    result = A ^ B;
      OP_LSL:    result = {A[6:0], 1'b0};
      OP_LSR:    result = {1'b0, A[7:1]};
      OP_ASL:    result = {A[6:0], 1'b0};
      OP_ASR:    result = {A[7], A[7:1]};
      OP_CSR:    result = {A[0], A[7:1]};
      default:   result = 8'h00;
    endcase
  end

  assign OutALU = result;

  // Compare reports flags of the difference, not of the selected output.
  assign flag_src = (op == OP_CMP) ? sub_sum[7:0] : result;

  always_comb begin
    z_d = (flag_src == 8'h00);
    n_d = flag_src[7];
    c_d = c_q;
    case (op)
      OP_ADD:                 c_d = add_sum[8];
      OP_SUB, OP_CMP:         c_d = sub_sum[8];
      OP_LSL, OP_ASL:         c_d = A[7];
      OP_LSR, OP_ASR, OP_CSR: c_d = A[0];
      default:                c_d = c_q;
    endcase
  end

`ifdef ALU_UNIT_OVERFLOW_EN
  logic add_ovf;
  logic sub_ovf;

  assign add_ovf = (A[7] == B[7]) && (add_sum[7] != A[7]);
  assign sub_ovf = (A[7] != B[7]) && (sub_sum[7] != A[7]);

  always_comb begin
    o_d = o_q;
    case (op)
      OP_ADD:         o_d = add_ovf;
      OP_SUB, OP_CMP: o_d = sub_ovf;
      OP_ASL:         o_d = A[7] ^ A[6];
      default:        o_d = o_q;
    endcase
  end
`else
  assign o_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
      n_q <= 1'b0;
      o_q <= 1'b0;
    end else begin
      z_q <= z_d;
      c_q <= c_d;
      n_q <= n_d;
      o_q <= o_d;
    end
  end

  assign Flags = {z_q, c_q, n_q, o_q};

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: vector table, hand-written corner sequences,
// randomized vectors, with a queue of expected flag values checked after each edge.
module tb_alu_unit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] FunSel;
  logic [7:0] OutALU;
  logic [3:0] Flags;

  int total;
  int bad;

  logic       mdl_c;
  logic       mdl_o;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] fun;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
  } vec_t;

  vec_t tbl[20];

  alu_unit dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .FunSel(FunSel),
    .OutALU(OutALU),
    .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] refOut(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    int ai;
    int bi;
    int r;
    ai = int'(a);
    bi = int'(b);
    r = 0;
    case (f)
      4'h0: r = ai;
      4'h1: r = bi;
      4'h2: r = 255 - ai;
      4'h3: r = 255 - bi;
      4'h4: r = (ai + bi) % 256;
      4'h5: r = (ai - bi + 256) % 256;
      4'h6: r = (ai > bi) ? ai : 0;
      4'h7: r = int'(a & b);
      4'h8: r = int'(a | b);
      4'h9: r = 255 - int'(a & b);
      4'hA: r = int'(a ^ b);
      4'hB, 4'hD: r = (ai * 2) % 256;
      4'hC: r = ai / 2;
      4'hE: r = ai / 2 + ((ai >= 128) ? 128 : 0);
      4'hF: r = ai / 2 + (ai % 2) * 128;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [3:0] refFlags(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                          input logic c_old, input logic o_old);
    int ai;
    int bi;
    int sa;
    int sb;
    int s;
    int res;
    logic z;
    logic c;
    logic n;
    logic o;
    ai = int'(a);
    bi = int'(b);
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    res = (f == 4'h6) ? (ai - bi + 256) % 256 : int'(refOut(f, a, b));
    z = (res == 0);
    n = (res >= 128);
    c = c_old;
    o = o_old;
    case (f)
      4'h4: begin
        c = (ai + bi) > 255;
        s = sa + sb;
        o = (s > 127) || (s < -128);
      end
      4'h5, 4'h6: begin
        c = (ai >= bi);
        s = sa - sb;
        o = (s > 127) || (s < -128);
      end
      4'hB: c = (ai >= 128);
      4'hD: begin
        c = (ai >= 128);
        o = (((ai / 128) + (ai / 64)) % 2) == 1;
      end
      4'hC, 4'hE, 4'hF: c = (ai % 2) == 1;
      default: ;
    endcase
`ifndef ALU_UNIT_OVERFLOW_EN
    o = 1'b0;
`endif
    return {z, c, n, o};
  endfunction

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one operation, checks the combinational result and queues the flags expected after the edge.
  task automatic applyStimulus(input string name, input logic [3:0] f, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] exp_out);
    logic [3:0] ef;
    @(negedge clk);
    FunSel = f;
    A = a;
    B = b;
    #1;
    check({name, " out"}, OutALU, exp_out);
    ef = refFlags(f, a, b, mdl_c, mdl_o);
    mdl_c = ef[2];
    mdl_o = ef[0];
    exp_q.push_back(ef);
    checkOutput(name);
  endtask

  task automatic checkOutput(input string name);
    logic [3:0] ef;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s flags: got %h expected queued value (queue empty)", name, Flags);
    end else begin
      ef = exp_q.pop_front();
      check({name, " flags"}, {4'h0, Flags}, {4'h0, ef});
    end
  endtask

  initial begin
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    total = 0;
    bad = 0;
    mdl_c = 1'b0;
    mdl_o = 1'b0;

    tbl[0]  = '{4'h0, 8'h5A, 8'hC3, 8'h5A};
    tbl[1]  = '{4'h1, 8'h5A, 8'hC3, 8'hC3};
    tbl[2]  = '{4'h2, 8'h5A, 8'hC3, 8'hA5};
    tbl[3]  = '{4'h3, 8'h5A, 8'hC3, 8'h3C};
    tbl[4]  = '{4'h4, 8'hFF, 8'h01, 8'h00};
    tbl[5]  = '{4'h4, 8'h7F, 8'h01, 8'h80};
    tbl[6]  = '{4'h5, 8'h80, 8'h01, 8'h7F};
    tbl[7]  = '{4'h5, 8'h55, 8'h55, 8'h00};
    tbl[8]  = '{4'h6, 8'h40, 8'h40, 8'h00};
    tbl[9]  = '{4'h6, 8'hC0, 8'h10, 8'hC0};
    tbl[10] = '{4'h7, 8'hAA, 8'hF0, 8'hA0};
    tbl[11] = '{4'h8, 8'hA0, 8'h05, 8'hA5};
    tbl[12] = '{4'h9, 8'hFF, 8'h0F, 8'hF0};
    tbl[13] = '{4'hA, 8'hFF, 8'h0F, 8'hF0};
    tbl[14] = '{4'hB, 8'h81, 8'h00, 8'h02};
    tbl[15] = '{4'hC, 8'h81, 8'h00, 8'h40};
    tbl[16] = '{4'hD, 8'h40, 8'h00, 8'h80};
    tbl[17] = '{4'hE, 8'h81, 8'h00, 8'hC0};
    tbl[18] = '{4'hF, 8'h01, 8'h00, 8'h80};
    tbl[19] = '{4'h5, 8'h01, 8'h02, 8'hFF};

    rst = 1'b1;
    A = 8'h00;
    B = 8'h00;
    FunSel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {4'h0, Flags}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add 33+0F", 4'h4, 8'h33, 8'h0F, 8'h42);
    check("add 33+0F zcno", {4'h0, Flags}, 8'h00);
    applyStimulus("sub 07-FA", 4'h5, 8'h07, 8'hFA, 8'h0D);
    check("sub 07-FA zcno", {4'h0, Flags}, 8'h00);
    applyStimulus("cmp 40,38", 4'h6, 8'h40, 8'h38, 8'h40);
    check("cmp 40,38 zcno", {4'h0, Flags}, 8'h04);
    applyStimulus("cmp 38,40", 4'h6, 8'h38, 8'h40, 8'h00);
    applyStimulus("cmp 40,38 again", 4'h6, 8'h40, 8'h38, 8'h40);
    applyStimulus("and AA,F0", 4'h7, 8'hAA, 8'hF0, 8'hA0);
    check("and AA,F0 zcno", {4'h0, Flags}, 8'h06);
    applyStimulus("asl 80", 4'hD, 8'h80, 8'h00, 8'h00);
`ifdef ALU_UNIT_OVERFLOW_EN
    check("asl 80 zcno", {4'h0, Flags}, 8'h0D);
`else
    check("asl 80 zcno", {4'h0, Flags}, 8'h0C);
`endif
    applyStimulus("csr 80", 4'hF, 8'h80, 8'h00, 8'h40);
    check("csr 80 carry", {7'h0, Flags[2]}, 8'h00);
    applyStimulus("asl 80 again", 4'hD, 8'h80, 8'h00, 8'h00);

    // Reset raised between edges must clear flags without waiting for the clock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    FunSel = 4'hF;
    A = 8'h80;
    #1;
    check("async reset flags", {4'h0, Flags}, 8'h00);
    check("out during reset", OutALU, 8'h40);
    @(posedge clk);
    #1;
    check("reset over edge", {4'h0, Flags}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    mdl_c = 1'b0;
    mdl_o = 1'b0;
    applyStimulus("add FF+01 after reset", 4'h4, 8'hFF, 8'h01, 8'h00);
    check("resume zcno", {4'h0, Flags}, 8'h0C);

    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("tbl%0d", i), tbl[i].fun, tbl[i].a, tbl[i].b, tbl[i].out);
    end

    for (int i = 0; i < 48; i++) begin
      f = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      applyStimulus($sformatf("rnd%0d f%h", i, f), f, a, b, refOut(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
